// File: rtl/pkmc_flashctrl_mb_pkg.sv
// Shared types and elaboration helpers for the multi-beat flash controller.
package pkmc_flashctrl_mb_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RECOV,
        S_ACK
    } state_t;

    function automatic bit dw_legal(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32);
    endfunction

    function automatic int beats_of(input int dw);
        return 32 / dw;
    endfunction

    function automatic int shift_of(input int dw);
        return (dw == 32) ? 2 : ((dw == 16) ? 1 : 0);
    endfunction

    // Beat b owns the sel bits of the bytes it carries; reads need every beat.
    function automatic logic [3:0] beat_en(input logic we, input logic [3:0] sel, input int beats);
        logic [3:0] en;
        logic [3:0] s;
        int         bpb;
        en  = '0;
        bpb = 4 / beats;
        for (int b = 0; b < 4; b++) begin
            s = sel << (b * bpb);
            if (b < beats) begin
                if (!we) en[b] = 1'b1;
                for (int k = 0; k < 4; k++)
                    if (k < bpb && s[3-k]) en[b] = 1'b1;
            end
        end
        return en;
    endfunction

    // Returns {found, index} of the lowest enabled beat at or above start.
    function automatic logic [2:0] find_beat(input logic [3:0] en, input int start);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--)
            if (i >= start && en[i]) r = {1'b1, 2'(i)};
        return r;
    endfunction

endpackage

// File: rtl/pkmc_flash_waitcnt.sv
// Loadable down-counter with zero flag, times each flash phase.
// Latency: load visible next cycle; decrements once per cycle down to zero.
// Backpressure: none; load always wins over decrement.
module pkmc_flash_waitcnt
    import pkmc_flashctrl_mb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pkmc_flashctrl_mb.sv
// Splits one 32-bit bus access into 1/2/4 flash beats with programmable setup/strobe/recovery.
// Latency: ack in cycle N*(TSU+Tx+TREC)+1 after the accepting edge, N = executed beats.
// Backpressure: decoder holds active until ack_o; dropping it aborts to IDLE without ack.
module pkmc_flashctrl_mb
    import pkmc_flashctrl_mb_pkg::*;
#(
    parameter int FLASH_DW = 16,
    parameter int FLASH_AW = 24,
    parameter int TSU      = 1,
    parameter int TRD      = 4,
    parameter int TWR      = 3,
    parameter int TREC     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                active,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         dat_i,
    input  logic [3:0]          sel_i,
    input  logic                we_i,
    output logic [31:0]         dat_o,
    output logic                ack_o,
    output logic [FLASH_AW-1:0] flashAddr,
    input  logic [FLASH_DW-1:0] flashData_i,
    output logic [FLASH_DW-1:0] flashData_o,
    output logic                flashCE,
    output logic                flashOE,
    output logic                flashWE,
    output logic                flashBuffDir,
    output logic                flashBuffOE
);

    localparam int                  BEATS = beats_of(FLASH_DW);
    localparam int                  SHIFT = shift_of(FLASH_DW);
    localparam logic [FLASH_AW-1:0] BMASK = FLASH_AW'(BEATS - 1);
    localparam logic [31:0]         LMASK = 32'((64'd1 << FLASH_DW) - 64'd1);

    generate
        if (!dw_legal(FLASH_DW) || TSU < 1 || TRD < 1 || TWR < 1 || TREC < 1) begin : g_bad_param
            $error("pkmc_flashctrl_mb: illegal FLASH_DW or zero timing parameter");
        end
    endgenerate

    function automatic int lane_shift(input logic [1:0] b);
        return (BEATS - 1 - int'(b)) * FLASH_DW;
    endfunction

    function automatic logic [FLASH_AW-1:0] beat_addr(input logic [31:0] a, input logic [1:0] b);
        return (FLASH_AW'(a >> SHIFT) & ~BMASK) | (FLASH_AW'(b) & BMASK);
    endfunction

    function automatic logic [FLASH_DW-1:0] wr_lane(input logic [31:0] d, input logic [1:0] b);
        return FLASH_DW'(d >> lane_shift(b));
    endfunction

    state_t                r_state;
    logic [1:0]            r_beat;
    logic                  r_we;
    logic [3:0]            r_en;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdat;
    logic [31:0]           r_rdat;
    logic                  r_ack;
    logic                  r_ce;
    logic                  r_oe;
    logic                  r_wen;
    logic                  r_boe;
    logic                  r_bdir;
    logic [FLASH_AW-1:0]   r_faddr;
    logic [FLASH_DW-1:0]   r_fdat;

    logic                  w_zero;
    logic                  w_load;
    logic [CNT_W-1:0]      w_val;
    logic [3:0]            w_en_in;
    logic [2:0]            w_first;
    logic [2:0]            w_next;

    assign w_en_in = beat_en(we_i, sel_i, BEATS);
    assign w_first = find_beat(w_en_in, 0);
    assign w_next  = find_beat(r_en, int'(r_beat) + 1);

    // The counter reloads whenever a phase ends, with the length of the phase that follows.
    assign w_load = (r_state == S_IDLE) || w_zero;
    always_comb begin
        w_val = CNT_W'(TSU - 1);
        case (r_state)
            S_SETUP:  w_val = r_we ? CNT_W'(TWR - 1) : CNT_W'(TRD - 1);
            S_STROBE: w_val = CNT_W'(TREC - 1);
            default:  w_val = CNT_W'(TSU - 1);
        endcase
    end

    pkmc_flash_waitcnt u_waitcnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_val),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_we    <= 1'b0;
            r_en    <= '0;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_rdat  <= '0;
            r_ack   <= 1'b0;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_wen   <= 1'b1;
            r_boe   <= 1'b1;
            r_bdir  <= 1'b0;
            r_faddr <= '0;
            r_fdat  <= '0;
        end else if (r_state != S_IDLE && !active) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_wen   <= 1'b1;
            r_boe   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack  <= 1'b0;
                    r_ce   <= 1'b1;
                    r_oe   <= 1'b1;
                    r_wen  <= 1'b1;
                    r_boe  <= 1'b1;
                    r_bdir <= 1'b0;
                    if (active) begin
                        r_we   <= we_i;
                        r_en   <= w_en_in;
                        r_addr <= addr_i;
                        r_wdat <= dat_i;
                        if (!w_first[2]) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_beat  <= w_first[1:0];
                            r_ce    <= 1'b0;
                            r_boe   <= 1'b0;
                            r_bdir  <= we_i;
                            r_faddr <= beat_addr(addr_i, w_first[1:0]);
                            r_fdat  <= wr_lane(dat_i, w_first[1:0]);
                        end
                    end
                end
                S_SETUP: begin
                    if (w_zero) begin
                        r_state <= S_STROBE;
                        r_oe    <= r_we;
                        r_wen   <= !r_we;
                    end
                end
                S_STROBE: begin
                    if (w_zero) begin
                        r_state <= S_RECOV;
                        r_oe    <= 1'b1;
                        r_wen   <= 1'b1;
                        if (!r_we)
                            r_rdat <= (r_rdat & ~(LMASK << lane_shift(r_beat)))
                                    | (32'(flashData_i) << lane_shift(r_beat));
                    end
                end
                S_RECOV: begin
                    if (w_zero) begin
                        if (w_next[2]) begin
                            r_state <= S_SETUP;
                            r_beat  <= w_next[1:0];
                            r_faddr <= beat_addr(r_addr, w_next[1:0]);
                            r_fdat  <= wr_lane(r_wdat, w_next[1:0]);
                        end else begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            r_ce    <= 1'b1;
                            r_boe   <= 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dat_o        = r_rdat;
    assign ack_o        = r_ack;
    assign flashAddr    = r_faddr;
    assign flashData_o  = r_fdat;
    assign flashCE      = r_ce;
    assign flashOE      = r_oe;
    assign flashWE      = r_wen;
    assign flashBuffDir = r_bdir;
    assign flashBuffOE  = r_boe;

endmodule

// File: tb/tb_pkmc_flashctrl_mb.sv
// Directed bench for pkmc_flashctrl_mb: default 16-bit, 8-bit (TSU=2,TRD=2) and 32-bit (TSU=2) instances.
module tb_pkmc_flashctrl_mb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_addr = '0;
    logic [31:0] i_dat  = '0;
    logic [3:0]  i_sel  = '0;
    logic        i_we   = 1'b0;
    logic        act0 = 1'b0, act1 = 1'b0, act2 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic [31:0] d0_dat; logic d0_ack; logic [23:0] d0_addr; logic [15:0] d0_fdi, d0_fdo;
    logic d0_ce, d0_oe, d0_we, d0_bdir, d0_boe;
    logic [31:0] d1_dat; logic d1_ack; logic [23:0] d1_addr; logic [7:0] d1_fdi, d1_fdo;
    logic d1_ce, d1_oe, d1_we, d1_bdir, d1_boe;
    logic [31:0] d2_dat; logic d2_ack; logic [23:0] d2_addr; logic [31:0] d2_fdi, d2_fdo;
    logic d2_ce, d2_oe, d2_we, d2_bdir, d2_boe;

    // Flash contents
    assign d0_fdi = (d0_addr == 24'h80) ? 16'hABCD : (d0_addr == 24'h81) ? 16'h1234 : 16'h0000;
    assign d1_fdi = (d1_addr == 24'h40) ? 8'h11 : (d1_addr == 24'h41) ? 8'h22 :
                    (d1_addr == 24'h42) ? 8'h33 : (d1_addr == 24'h43) ? 8'h44 : 8'h00;
    assign d2_fdi = (d2_addr == 24'h40) ? 32'hCAFEF00D : 32'h0;

    pkmc_flashctrl_mb u_dut (
        .clk(clk), .rst(rst), .active(act0), .addr_i(i_addr), .dat_i(i_dat), .sel_i(i_sel),
        .we_i(i_we), .dat_o(d0_dat), .ack_o(d0_ack), .flashAddr(d0_addr), .flashData_i(d0_fdi),
        .flashData_o(d0_fdo), .flashCE(d0_ce), .flashOE(d0_oe), .flashWE(d0_we),
        .flashBuffDir(d0_bdir), .flashBuffOE(d0_boe));

    pkmc_flashctrl_mb #(.FLASH_DW(8), .TSU(2), .TRD(2), .TREC(1)) u_dut8 (
        .clk(clk), .rst(rst), .active(act1), .addr_i(i_addr), .dat_i(i_dat), .sel_i(i_sel),
        .we_i(i_we), .dat_o(d1_dat), .ack_o(d1_ack), .flashAddr(d1_addr), .flashData_i(d1_fdi),
        .flashData_o(d1_fdo), .flashCE(d1_ce), .flashOE(d1_oe), .flashWE(d1_we),
        .flashBuffDir(d1_bdir), .flashBuffOE(d1_boe));

    pkmc_flashctrl_mb #(.FLASH_DW(32), .TSU(2)) u_dut32 (
        .clk(clk), .rst(rst), .active(act2), .addr_i(i_addr), .dat_i(i_dat), .sel_i(i_sel),
        .we_i(i_we), .dat_o(d2_dat), .ack_o(d2_ack), .flashAddr(d2_addr), .flashData_i(d2_fdi),
        .flashData_o(d2_fdo), .flashCE(d2_ce), .flashOE(d2_oe), .flashWE(d2_we),
        .flashBuffDir(d2_bdir), .flashBuffOE(d2_boe));

    // Runs one access on the selected instance and records what the flash pins did.
    // Called and returns at a negedge; ack_cyc = -1 if no ack within the budget.
    task automatic run_acc(input int which, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] dat,
                           output int ack_cyc, output logic [31:0] rd, output int oe_low,
                           output int we_low, output int nstb, output int viol,
                           output logic [31:0] sd0, output logic [31:0] sa0,
                           output logic [31:0] sd1, output logic [31:0] sa1);
        logic s_ack, s_oe, s_we, s_ce, s_boe, s_bdir, prev_we;
        logic [31:0] s_dat, s_adr, s_wd;
        ack_cyc = -1; rd = '0; oe_low = 0; we_low = 0; nstb = 0; viol = 0;
        sd0 = '0; sa0 = '0; sd1 = '0; sa1 = '0; prev_we = 1'b1;
        i_we = we; i_sel = sel; i_addr = addr; i_dat = dat;
        case (which)
            0: act0 = 1'b1;
            1: act1 = 1'b1;
            default: act2 = 1'b1;
        endcase
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            case (which)
                0: begin s_ack = d0_ack; s_dat = d0_dat; s_oe = d0_oe; s_we = d0_we; s_ce = d0_ce;
                         s_boe = d0_boe; s_bdir = d0_bdir; s_adr = 32'(d0_addr); s_wd = 32'(d0_fdo); end
                1: begin s_ack = d1_ack; s_dat = d1_dat; s_oe = d1_oe; s_we = d1_we; s_ce = d1_ce;
                         s_boe = d1_boe; s_bdir = d1_bdir; s_adr = 32'(d1_addr); s_wd = 32'(d1_fdo); end
                default: begin s_ack = d2_ack; s_dat = d2_dat; s_oe = d2_oe; s_we = d2_we; s_ce = d2_ce;
                         s_boe = d2_boe; s_bdir = d2_bdir; s_adr = 32'(d2_addr); s_wd = 32'(d2_fdo); end
            endcase
            if (!s_oe) oe_low++;
            if (!s_we) begin
                we_low++;
                if (prev_we) begin
                    if (nstb == 0) begin sd0 = s_wd; sa0 = s_adr; end
                    else begin sd1 = s_wd; sa1 = s_adr; end
                    nstb++;
                end
            end
            if ((!s_oe || !s_we) && (s_ce || s_boe || (s_bdir != !s_we))) viol++;
            prev_we = s_we;
            if (s_ack) begin
                ack_cyc = cyc;
                rd = s_dat;
                break;
            end
        end
        act0 = 1'b0; act1 = 1'b0; act2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (d0_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", d0_ack); end
        n_checks++; if (d0_dat !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", d0_dat); end
        n_checks++; if ({d0_ce, d0_oe, d0_we, d0_boe} !== 4'b1111) begin n_fail++;
            $display("FAIL rst_strobes: got %b want 1111", {d0_ce, d0_oe, d0_we, d0_boe}); end
        n_checks++; if (d0_bdir !== 1'b0) begin n_fail++; $display("FAIL rst_bdir: got %b want 0", d0_bdir); end
        n_checks++; if (d0_addr !== 24'h0 || d0_fdo !== 16'h0) begin n_fail++;
            $display("FAIL rst_addr_data: got %h/%h want 0/0", d0_addr, d0_fdo); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read;
        int ac, ol, wl, ns, vi; logic [31:0] rd, sd0, sa0, sd1, sa1;
        run_acc(0, 1'b0, 4'b0000, 32'h100, 32'h0, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 13) begin n_fail++; $display("FAIL rd_ack_cycle: got %0d want 13", ac); end
        n_checks++; if (rd !== 32'hABCD1234) begin n_fail++; $display("FAIL rd_data: got %h want ABCD1234", rd); end
        n_checks++; if (ol !== 8 || wl !== 0) begin n_fail++; $display("FAIL rd_strobe_cycles: got oe=%0d we=%0d want 8/0", ol, wl); end
        n_checks++; if (vi !== 0) begin n_fail++; $display("FAIL rd_ctrl_viol: got %0d want 0", vi); end
    endtask

    task automatic test_write_full;
        int ac, ol, wl, ns, vi; logic [31:0] rd, sd0, sa0, sd1, sa1;
        run_acc(0, 1'b1, 4'b1111, 32'h200, 32'hDEADBEEF, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 11) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d want 11", ac); end
        n_checks++; if (ns !== 2 || wl !== 6 || ol !== 0) begin n_fail++;
            $display("FAIL wr_strobes: got n=%0d we=%0d oe=%0d want 2/6/0", ns, wl, ol); end
        n_checks++; if (sd0 !== 32'hDEAD || sa0 !== 32'h100) begin n_fail++;
            $display("FAIL wr_beat0: got %h@%h want DEAD@100", sd0, sa0); end
        n_checks++; if (sd1 !== 32'hBEEF || sa1 !== 32'h101) begin n_fail++;
            $display("FAIL wr_beat1: got %h@%h want BEEF@101", sd1, sa1); end
        n_checks++; if (vi !== 0) begin n_fail++; $display("FAIL wr_ctrl_viol: got %0d want 0", vi); end
    endtask

    task automatic test_write_partial;
        int ac, ol, wl, ns, vi; logic [31:0] rd, sd0, sa0, sd1, sa1;
        run_acc(0, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 6) begin n_fail++; $display("FAIL wr_lo_ack_cycle: got %0d want 6", ac); end
        n_checks++; if (ns !== 1 || wl !== 3) begin n_fail++; $display("FAIL wr_lo_strobes: got n=%0d we=%0d want 1/3", ns, wl); end
        n_checks++; if (sd0 !== 32'hBEEF || sa0 !== 32'h101) begin n_fail++;
            $display("FAIL wr_lo_beat: got %h@%h want BEEF@101", sd0, sa0); end
        run_acc(0, 1'b1, 4'b0000, 32'h200, 32'hDEADBEEF, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 1) begin n_fail++; $display("FAIL wr_nosel_ack_cycle: got %0d want 1", ac); end
        n_checks++; if (wl !== 0) begin n_fail++; $display("FAIL wr_nosel_we: got %0d want 0", wl); end
    endtask

    task automatic test_abort;
        int ac, ol, wl, ns, vi, seen, acks; logic [31:0] rd, sd0, sa0, sd1, sa1;
        i_we = 1'b0; i_sel = 4'b1111; i_addr = 32'h100; act0 = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (!d0_oe) begin seen = 1; break; end
        end
        n_checks++; if (seen !== 1) begin n_fail++; $display("FAIL abort_oe_seen: got %0d want 1", seen); end
        act0 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({d0_ce, d0_oe, d0_we, d0_ack} !== 4'b1110) begin n_fail++;
            $display("FAIL abort_pins: got ce/oe/we/ack=%b want 1110", {d0_ce, d0_oe, d0_we, d0_ack}); end
        acks = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (d0_ack) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d want 0", acks); end
        run_acc(0, 1'b0, 4'b0000, 32'h100, 32'h0, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 13 || rd !== 32'hABCD1234) begin n_fail++;
            $display("FAIL abort_reread: got cyc=%0d dat=%h want 13/ABCD1234", ac, rd); end
    endtask

    task automatic test_rst_mid_write;
        int nstb; logic prev;
        i_we = 1'b1; i_sel = 4'b1111; i_addr = 32'h200; i_dat = 32'hDEADBEEF; act0 = 1'b1;
        nstb = 0; prev = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); @(negedge clk);
            if (!d0_we && prev) nstb++;
            prev = d0_we;
            if (nstb == 2) break;
        end
        n_checks++; if (nstb !== 2 || d0_addr !== 24'h101) begin n_fail++;
            $display("FAIL rstw_reach_beat1: got n=%0d addr=%h want 2/101", nstb, d0_addr); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({d0_ce, d0_oe, d0_we, d0_boe, d0_bdir, d0_ack} !== 6'b111100) begin n_fail++;
            $display("FAIL rstw_pins: got %b want 111100", {d0_ce, d0_oe, d0_we, d0_boe, d0_bdir, d0_ack}); end
        n_checks++; if (d0_addr !== 24'h0 || d0_fdo !== 16'h0 || d0_dat !== 32'h0) begin n_fail++;
            $display("FAIL rstw_regs: got %h/%h/%h want 0/0/0", d0_addr, d0_fdo, d0_dat); end
        @(negedge clk);
        rst = 1'b0; act0 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (d0_ce !== 1'b1 || d0_we !== 1'b1) begin n_fail++;
            $display("FAIL rstw_no_resume: got ce=%b we=%b want 1/1", d0_ce, d0_we); end
    endtask

    task automatic test_dw8;
        int ac, ol, wl, ns, vi; logic [31:0] rd, sd0, sa0, sd1, sa1;
        run_acc(1, 1'b0, 4'b1111, 32'h40, 32'h0, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 21) begin n_fail++; $display("FAIL dw8_ack_cycle: got %0d want 21", ac); end
        n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL dw8_data: got %h want 11223344", rd); end
        n_checks++; if (ol !== 8 || vi !== 0) begin n_fail++; $display("FAIL dw8_oe: got oe=%0d viol=%0d want 8/0", ol, vi); end
    endtask

    task automatic test_dw32;
        int ac, ol, wl, ns, vi; logic [31:0] rd, sd0, sa0, sd1, sa1;
        run_acc(2, 1'b0, 4'b1111, 32'h100, 32'h0, ac, rd, ol, wl, ns, vi, sd0, sa0, sd1, sa1);
        n_checks++; if (ac !== 8) begin n_fail++; $display("FAIL dw32_ack_cycle: got %0d want 8", ac); end
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL dw32_data: got %h want CAFEF00D", rd); end
        n_checks++; if (ol !== 4 || vi !== 0) begin n_fail++; $display("FAIL dw32_oe: got oe=%0d viol=%0d want 4/0", ol, vi); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_full();
        test_write_partial();
        test_abort();
        test_rst_mid_write();
        test_dw8();
        test_dw32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
